// File: rtl/beta_data_mem_resp.sv
// Data-memory responder for the BETA core: word RAM behind an MA/MOE/MWR/MWD
// request port with a fixed number of wait states and a one-cycle MRDY/MERR ack.
module beta_data_mem_resp #(
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE        = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] MA,
  input  logic        MOE,
  input  logic        MWR,
  input  logic [31:0] MWD,
  output logic [31:0] MRD,
  output logic        MRDY,
  output logic        MERR
);

  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic [31:0]            addr_q;
  logic [31:0]            wd_q;
  logic                   we_q;
  logic [31:0]            mrd_q;
  logic                   mrdy_q;
  logic                   merr_q;
  logic [31:0]            mem_q [DEPTH];

  logic                   req;
  logic                   go_ack;
  logic [31:0]            acc_addr;
  logic [31:0]            acc_wd;
  logic                   acc_we;
  logic [31:0]            acc_off;
  logic                   acc_in_range;
  logic [ADDR_BITS-1:0]   acc_idx;
  logic                   unused_byte_off;

  assign req = MOE | MWR;

  // With zero wait states the access completes on the sampling edge itself,
  // so the live bus values stand in for the not-yet-latched copies.
  always_comb begin
    acc_addr = addr_q;
    acc_wd   = wd_q;
    acc_we   = we_q;
    if (state_q == S_IDLE) begin
      acc_addr = MA;
      acc_wd   = MWD;
      acc_we   = MWR;
    end
  end

  assign acc_off         = acc_addr - BASE;
  assign acc_in_range    = (acc_off[31:ADDR_BITS+2] == '0);
  assign acc_idx         = acc_off[ADDR_BITS+1:2];
  assign unused_byte_off = ^acc_off[1:0];

  assign go_ack = ((state_q == S_IDLE) && req && (WS == 4'd0)) ||
                  ((state_q == S_WAIT) && (cnt_q == 4'd1));

  // Array is never cleared; a reset on the committing edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RESET && go_ack && acc_we && acc_in_range)
      mem_q[acc_idx] <= acc_wd;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      we_q    <= 1'b0;
      mrd_q   <= 32'd0;
      mrdy_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      mrdy_q <= 1'b0;
      merr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= MA;
            wd_q    <= MWD;
            we_q    <= MWR;
            cnt_q   <= WS;
            state_q <= (WS == 4'd0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1)
            state_q <= S_ACK;
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (go_ack) begin
        mrdy_q <= 1'b1;
        merr_q <= !acc_in_range;
        if (!acc_we)
          mrd_q <= acc_in_range ? mem_q[acc_idx] : 32'd0;
      end
    end
  end

  assign MRD  = mrd_q;
  assign MRDY = mrdy_q;
  assign MERR = merr_q;

endmodule
